// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
// Also supplies the RegAddrBus register-address range macro.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

package hazard_pkg;

  localparam int MC_LAT_DEF = 8;
  localparam int CNT_W_DEF  = 6;

  typedef enum logic [0:0] {MC_IDLE, MC_BUSY} mc_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_exe_write;
    logic exe_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_exe_flush;
    logic exe_mem_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    id_exe_write:  1'b1,
    exe_mem_write: 1'b1,
    mem_wb_write:  1'b1,
    if_id_flush:   1'b0,
    id_exe_flush:  1'b0,
    exe_mem_flush: 1'b0
  };

endpackage

// File: rtl/hazard_stall_ctrl_mc_seq.sv
// mc_seq: latency sequencer for multi-cycle EXE ops (MUL/DIV/FDIV).
// Holds state and counter whenever the memory system stalls.
module mc_seq
  import hazard_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic hold_i,
  output logic stall_o,
  output logic busy_o,
  output logic done_o
);

  localparam bit MULTI = (MC_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MULTI ? MC_LAT - 2 : 0);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      unique case (state_q)
        MC_IDLE: begin
          if (start_i && MULTI) begin
            state_d = MC_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        MC_BUSY: begin
          if (cnt_q == '0) state_d = MC_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      endcase
    end
  end

  // The start cycle itself already counts as a stalled EXE cycle.
  always_comb begin
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        MC_IDLE: begin
          busy_o  = start_i;
          stall_o = start_i && MULTI;
          done_o  = start_i && !MULTI;
        end
        MC_BUSY: begin
          busy_o  = 1'b1;
          stall_o = (cnt_q != '0);
          done_o  = (cnt_q == '0);
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use detection and stall/flush merging.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`RegAddrBus] ID_rs1_addr,
  input  logic [`RegAddrBus] ID_rs2_addr,
  input  logic              ID_rs1_fp,
  input  logic              ID_rs2_fp,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic [`RegAddrBus] EXE_rd_addr,
  input  logic              EXE_mem_read,
  input  logic              EXE_gen_reg_write,
  input  logic              EXE_fp_reg_write,
  input  logic              EXE_mc_start,
  input  logic              EXE_branch_taken,
  input  logic              IM_stall,
  input  logic              DM_stall,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic              ID_EXE_write,
  output logic              EXE_MEM_write,
  output logic              MEM_WB_write,
  output logic              IF_ID_flush,
  output logic              ID_EXE_flush,
  output logic              EXE_MEM_flush,
  output logic              mc_busy,
  output logic              mc_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic     memstall, mcstall;
  logic     rs1_hit, rs2_hit, lu;
  hz_ctrl_t ctrl;

  assign memstall = IM_stall | DM_stall;

  mc_seq #(
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (EXE_mc_start),
    .hold_i  (memstall),
    .stall_o (mcstall),
    .busy_o  (mc_busy),
    .done_o  (mc_done)
  );

  // x0 is hardwired zero, f0 is a real register.
  assign rs1_hit = ID_rs1_used
                 && (ID_rs1_addr == EXE_rd_addr)
                 && (ID_rs1_fp ? EXE_fp_reg_write
                               : (EXE_gen_reg_write
                                  && ID_rs1_addr != '0));
  assign rs2_hit = ID_rs2_used
                 && (ID_rs2_addr == EXE_rd_addr)
                 && (ID_rs2_fp ? EXE_fp_reg_write
                               : (EXE_gen_reg_write
                                  && ID_rs2_addr != '0));
  assign lu = EXE_mem_read && (rs1_hit || rs2_hit);

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RUN;
    end else if (memstall) begin
      ctrl = '0;
    end else if (mcstall) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_exe_write  = 1'b0;
      ctrl.exe_mem_flush = 1'b1;
    end else if (EXE_branch_taken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_exe_flush = 1'b1;
    end else if (lu) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_exe_flush = 1'b1;
    end
  end

  assign PC_write      = ctrl.pc_write;
  assign IF_ID_write   = ctrl.if_id_write;
  assign ID_EXE_write  = ctrl.id_exe_write;
  assign EXE_MEM_write = ctrl.exe_mem_write;
  assign MEM_WB_write  = ctrl.mem_wb_write;
  assign IF_ID_flush   = ctrl.if_id_flush;
  assign ID_EXE_flush  = ctrl.id_exe_flush;
  assign EXE_MEM_flush = ctrl.exe_mem_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!ctrl.pc_write)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (ctrl.if_id_flush | ctrl.id_exe_flush
          | ctrl.exe_mem_flush)
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, hand sequences and random
// stimulus against a remaining-cycles reference model.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

module tb_hazard_stall_ctrl;

  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_MEM = 8'b00000_000;
  localparam logic [7:0] C_MC  = 8'b00011_001;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_LU  = 8'b00111_010;

  logic clk, rst;
  logic [`RegAddrBus] ID_rs1_addr, ID_rs2_addr, EXE_rd_addr;
  logic ID_rs1_fp, ID_rs2_fp, ID_rs1_used, ID_rs2_used;
  logic EXE_mem_read, EXE_gen_reg_write, EXE_fp_reg_write;
  logic EXE_mc_start, EXE_branch_taken, IM_stall, DM_stall;

  logic a_pc, a_ifid, a_idexe, a_exmem, a_memwb;
  logic a_ifid_f, a_idexe_f, a_exmem_f, a_busy, a_done;
  logic b_pc, b_ifid, b_idexe, b_exmem, b_memwb;
  logic b_ifid_f, b_idexe_f, b_exmem_f, b_busy, b_done;
  logic [9:0] o8, o1;

  assign o8 = {a_pc, a_ifid, a_idexe, a_exmem, a_memwb,
               a_ifid_f, a_idexe_f, a_exmem_f, a_busy, a_done};
  assign o1 = {b_pc, b_ifid, b_idexe, b_exmem, b_memwb,
               b_ifid_f, b_idexe_f, b_exmem_f, b_busy, b_done};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_ps, a_pf, b_ps, b_pf;
`endif

  hazard_stall_ctrl #(.MC_LAT(8), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_fp(ID_rs1_fp), .ID_rs2_fp(ID_rs2_fp),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EXE_rd_addr(EXE_rd_addr), .EXE_mem_read(EXE_mem_read),
    .EXE_gen_reg_write(EXE_gen_reg_write),
    .EXE_fp_reg_write(EXE_fp_reg_write),
    .EXE_mc_start(EXE_mc_start),
    .EXE_branch_taken(EXE_branch_taken),
    .IM_stall(IM_stall), .DM_stall(DM_stall),
    .PC_write(a_pc), .IF_ID_write(a_ifid),
    .ID_EXE_write(a_idexe), .EXE_MEM_write(a_exmem),
    .MEM_WB_write(a_memwb), .IF_ID_flush(a_ifid_f),
    .ID_EXE_flush(a_idexe_f), .EXE_MEM_flush(a_exmem_f),
    .mc_busy(a_busy), .mc_done(a_done)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cyc(a_ps), .perf_flush_cnt(a_pf)
`endif
  );

  hazard_stall_ctrl #(.MC_LAT(1), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_fp(ID_rs1_fp), .ID_rs2_fp(ID_rs2_fp),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EXE_rd_addr(EXE_rd_addr), .EXE_mem_read(EXE_mem_read),
    .EXE_gen_reg_write(EXE_gen_reg_write),
    .EXE_fp_reg_write(EXE_fp_reg_write),
    .EXE_mc_start(EXE_mc_start),
    .EXE_branch_taken(EXE_branch_taken),
    .IM_stall(IM_stall), .DM_stall(DM_stall),
    .PC_write(b_pc), .IF_ID_write(b_ifid),
    .ID_EXE_write(b_idexe), .EXE_MEM_write(b_exmem),
    .MEM_WB_write(b_memwb), .IF_ID_flush(b_ifid_f),
    .ID_EXE_flush(b_idexe_f), .EXE_MEM_flush(b_exmem_f),
    .mc_busy(b_busy), .mc_done(b_done)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cyc(b_ps), .perf_flush_cnt(b_pf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining EXE cycles of the op (0 = none).
  int rem8 = 0, rem1 = 0;
  logic [31:0] ps8 = 0, pf8 = 0, ps1 = 0, pf1 = 0;
  logic [7:0] mc8, mc1;
  logic mem_m;

  function automatic void mc_eval(int lat, int rem, logic start,
                                  output logic st, output logic dn,
                                  output logic bz);
    if (rem == 0) begin
      bz = start;
      st = start && (lat > 1);
      dn = start && (lat == 1);
    end else begin
      bz = 1'b1;
      st = (rem > 1);
      dn = (rem == 1);
    end
  endfunction

  function automatic int mc_next(int lat, int rem, logic start,
                                 logic hold);
    if (hold) return rem;
    if (rem > 0) return rem - 1;
    if (start && lat > 1) return lat - 1;
    return 0;
  endfunction

  function automatic logic model_lu();
    logic hit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [4:0] a  = (s == 0) ? ID_rs1_addr : ID_rs2_addr;
      logic       fp = (s == 0) ? ID_rs1_fp : ID_rs2_fp;
      logic       u  = (s == 0) ? ID_rs1_used : ID_rs2_used;
      logic file_ok = fp ? EXE_fp_reg_write
                         : (EXE_gen_reg_write && a != 5'd0);
      if (u && a == EXE_rd_addr && file_ok) hit = 1'b1;
    end
    return EXE_mem_read && hit;
  endfunction

  function automatic logic [7:0] exp_ctrl(logic r, logic m,
                                          logic mcst, logic br,
                                          logic l);
    if (r)    return C_RUN;
    if (m)    return C_MEM;
    if (mcst) return C_MC;
    if (br)   return C_BR;
    if (l)    return C_LU;
    return C_RUN;
  endfunction

  task automatic settle();
    logic st, dn, bz, l;
    logic [9:0] e;
    #1;
    mem_m = IM_stall | DM_stall;
    l = model_lu();
    mc_eval(8, rem8, EXE_mc_start, st, dn, bz);
    mc8 = exp_ctrl(rst, mem_m, st, EXE_branch_taken, l);
    e = rst ? {mc8, 2'b00} : {mc8, bz, dn};
    chk("model_lat8", 32'(o8), 32'(e));
    mc_eval(1, rem1, EXE_mc_start, st, dn, bz);
    mc1 = exp_ctrl(rst, mem_m, st, EXE_branch_taken, l);
    e = rst ? {mc1, 2'b00} : {mc1, bz, dn};
    chk("model_lat1", 32'(o1), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall8", a_ps, ps8);
    chk("perf_flush8", a_pf, pf8);
    chk("perf_stall1", b_ps, ps1);
    chk("perf_flush1", b_pf, pf1);
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      rem8 = 0; rem1 = 0;
      ps8 = 0; pf8 = 0; ps1 = 0; pf1 = 0;
    end else begin
      rem8 = mc_next(8, rem8, EXE_mc_start, mem_m);
      rem1 = mc_next(1, rem1, EXE_mc_start, mem_m);
      ps8 += 32'(!mc8[7]);
      pf8 += 32'(|mc8[2:0]);
      ps1 += 32'(!mc1[7]);
      pf1 += 32'(|mc1[2:0]);
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    ID_rs1_addr = '0; ID_rs2_addr = '0; EXE_rd_addr = '0;
    ID_rs1_fp = 0; ID_rs2_fp = 0;
    ID_rs1_used = 0; ID_rs2_used = 0;
    EXE_mem_read = 0; EXE_gen_reg_write = 0;
    EXE_fp_reg_write = 0; EXE_mc_start = 0;
    EXE_branch_taken = 0; IM_stall = 0; DM_stall = 0;
  endtask

  typedef struct {
    logic [4:0] a1; logic f1, u1;
    logic [4:0] a2; logic f2, u2;
    logic [4:0] rd; logic mr, gw, fw, br;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mkv(int a1, int f1, int u1, int a2,
                               int f2, int u2, int rd, int mr,
                               int gw, int fw, int br,
                               logic [7:0] exp);
    vec_t v;
    v.a1 = 5'(a1); v.f1 = 1'(f1); v.u1 = 1'(u1);
    v.a2 = 5'(a2); v.f2 = 1'(f2); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.mr = 1'(mr); v.gw = 1'(gw);
    v.fw = 1'(fw); v.br = 1'(br); v.exp = exp;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [9:0] e8, e1;
    vecs[0] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, C_LU);
    vecs[1] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0, C_RUN);
    vecs[2] = mkv(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, C_RUN);
    vecs[3] = mkv(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, C_LU);
    vecs[4] = mkv(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, C_RUN);
    vecs[5] = mkv(1, 0, 1, 7, 0, 1, 7, 1, 1, 0, 0, C_LU);
    vecs[6] = mkv(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, C_RUN);
    vecs[7] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 1, C_BR);
    vecs[8] = mkv(2, 0, 1, 3, 0, 1, 9, 0, 1, 0, 1, C_BR);
    vecs[9] = mkv(0, 0, 0, 3, 0, 1, 3, 1, 0, 1, 0, C_RUN);

    idle_in();
    rst = 1'b1;
    EXE_mc_start = 1; DM_stall = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("reset8", 32'(o8), 32'({C_RUN, 2'b00}));
      chk("reset1", 32'(o1), 32'({C_RUN, 2'b00}));
      adv();
    end
    rst = 1'b0;
    idle_in();

    for (int i = 0; i < 10; i++) begin
      ID_rs1_addr = vecs[i].a1; ID_rs1_fp = vecs[i].f1;
      ID_rs1_used = vecs[i].u1; ID_rs2_addr = vecs[i].a2;
      ID_rs2_fp = vecs[i].f2; ID_rs2_used = vecs[i].u2;
      EXE_rd_addr = vecs[i].rd; EXE_mem_read = vecs[i].mr;
      EXE_gen_reg_write = vecs[i].gw;
      EXE_fp_reg_write = vecs[i].fw;
      EXE_branch_taken = vecs[i].br;
      settle();
      chk($sformatf("vec%0d_lat8", i), 32'(o8),
          32'({vecs[i].exp, 2'b00}));
      chk($sformatf("vec%0d_lat1", i), 32'(o1),
          32'({vecs[i].exp, 2'b00}));
      adv();
      if (i == 0) begin
        EXE_mem_read = 0; EXE_gen_reg_write = 0;
        settle();
        chk("lu_bubble_next", 32'(o8), 32'({C_RUN, 2'b00}));
        adv();
      end
    end
    idle_in();

    EXE_mc_start = 1;
    for (int i = 1; i <= 8; i++) begin
      settle();
      e8 = (i < 8) ? {C_MC, 2'b10} : {C_RUN, 2'b11};
      chk($sformatf("mc8_cyc%0d", i), 32'(o8), 32'(e8));
      chk($sformatf("mc1_cyc%0d", i), 32'(o1),
          32'({C_RUN, 2'b11}));
      adv();
    end
    EXE_mc_start = 0;
    settle();
    chk("mc8_after", 32'(o8), 32'({C_RUN, 2'b00}));
    adv();

    EXE_mc_start = 1;
    for (int i = 1; i <= 13; i++) begin
      DM_stall = (i >= 4 && i <= 6);
      IM_stall = (i == 11 || i == 12);
      settle();
      if (DM_stall)     e8 = {C_MEM, 2'b10};
      else if (i <= 10) e8 = {C_MC, 2'b10};
      else if (IM_stall) e8 = {C_MEM, 2'b11};
      else              e8 = {C_RUN, 2'b11};
      e1 = (DM_stall | IM_stall) ? {C_MEM, 2'b11}
                                 : {C_RUN, 2'b11};
      chk($sformatf("memst8_cyc%0d", i), 32'(o8), 32'(e8));
      chk($sformatf("memst1_cyc%0d", i), 32'(o1), 32'(e1));
      adv();
    end
    idle_in();
    settle();
    adv();

    EXE_mc_start = 1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      adv();
    end
    rst = 1'b1;
    settle();
    chk("rst_busy8", 32'(o8), 32'({C_RUN, 2'b00}));
    adv();
    rst = 1'b0;
    EXE_mc_start = 0;
    settle();
    chk("post_rst8", 32'(o8), 32'({C_RUN, 2'b00}));
`ifdef HAZARD_PERF_CNT_EN
    chk("post_rst_ps", a_ps, 32'd0);
    chk("post_rst_pf", a_pf, 32'd0);
`endif
    adv();

    for (int n = 0; n < 3000; n++) begin
      ID_rs1_addr = 5'($urandom_range(0, 3));
      ID_rs2_addr = 5'($urandom_range(0, 3));
      EXE_rd_addr = 5'($urandom_range(0, 3));
      ID_rs1_fp = 1'($urandom_range(0, 1));
      ID_rs2_fp = 1'($urandom_range(0, 1));
      ID_rs1_used = 1'($urandom_range(0, 1));
      ID_rs2_used = 1'($urandom_range(0, 1));
      EXE_mem_read = 1'($urandom_range(0, 1));
      EXE_gen_reg_write = 1'($urandom_range(0, 1));
      EXE_fp_reg_write = 1'($urandom_range(0, 1));
      EXE_mc_start = ($urandom_range(0, 5) == 0);
      EXE_branch_taken = ($urandom_range(0, 5) == 0);
      IM_stall = ($urandom_range(0, 9) == 0);
      DM_stall = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      settle();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
